tcdm_bank_responder: RTL and testbench

Multi-port TCDM responder: the memory-side end of the TCDM master ports that HWPE engines such as the MAC accelerator drive. It accepts `req/add/wen/be/data` from MP masters, grants at most one per cycle by round-robin, performs the access on an internal single-port word memory, and returns `r_data/r_valid` one cycle after the grant. It sits in the HWPE subsystem testbench and in small standalone clusters as the TCDM bank behind the accelerator's `tcdm_*` ports. A `stall_i` input provides back-pressure injection.

---
 rtl/tcdm_bank_responder_pkg.sv | 15 +
 rtl/tcdm_bank_responder_if.sv | 20 ++
 rtl/tcdm_bank_responder_rr_arbiter.sv | 30 +++
 rtl/tcdm_bank_responder.sv | 110 +++++++++++
 tb/tb_tcdm_bank_responder.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/tcdm_bank_responder_pkg.sv
// Shared constants and response payload type for the TCDM bank responder.
package tcdm_responder_package;

   localparam int unsigned TCDM_DW  = 32;
   localparam int unsigned TCDM_BEW = 4;
   localparam int unsigned TCDM_AW  = 32;
   localparam int unsigned TCDM_PW  = 8;

   typedef struct packed {
      logic               valid;
      logic [TCDM_PW-1:0] port;
      logic [TCDM_DW-1:0] data;
   } tcdm_rsp_t;

endpackage

// File: rtl/tcdm_bank_responder_if.sv
// TCDM multi-port bus: request/grant from masters, single-cycle response back.
interface tcdm_bank_responder_if
   import tcdm_responder_package::*;
#(
   parameter int unsigned MP = 4
);

   logic [MP-1:0]                req;
   logic [MP-1:0]                gnt;
   logic [MP-1:0][TCDM_AW-1:0]   add;
   logic [MP-1:0]                wen;
   logic [MP-1:0][TCDM_BEW-1:0]  be;
   logic [MP-1:0][TCDM_DW-1:0]   data;
   logic [MP-1:0][TCDM_DW-1:0]   r_data;
   logic [MP-1:0]                r_valid;

   modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
   modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);

endinterface

// File: rtl/tcdm_bank_responder_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr_i (with wrap) wins.
module tcdm_rr_arbiter #(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   input  logic          en_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      if (en_i) begin
         for (int unsigned off = 0; off < N; off++) begin
            automatic int unsigned p = (32'(ptr_i) + off) % N;
            if (!valid_o && req_i[p]) begin
               valid_o  = 1'b1;
               gnt_o[p] = 1'b1;
               idx_o    = IW'(p);
            end
         end
      end
   end

endmodule

// File: rtl/tcdm_bank_responder.sv
// Multi-port TCDM bank: round-robin grant, single-port word memory, 1-cycle response.
module tcdm_bank_responder
   import tcdm_responder_package::*;
#(
   parameter  int unsigned MP    = 4,
   parameter  int unsigned DEPTH = 1024,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned IW    = (MP > 1) ? $clog2(MP) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   stall_i,
   tcdm_bank_responder_if.slave   tcdm,
   output logic                   busy_o
);

   logic [IW-1:0]       ptr_q, ptr_d;
   logic [IW-1:0]       gnt_idx;
   logic                gnt_valid;
   logic                arb_en;
   logic [MP-1:0]       gnt;

   logic [TCDM_AW-1:0]  add_sel;
   logic [TCDM_BEW-1:0] be_sel;
   logic [TCDM_DW-1:0]  wdata_sel;
   logic                wen_sel;
   logic [AW-1:0]       widx;
   logic                wr_en;
   logic [TCDM_DW-1:0]  rd_word;

   tcdm_rsp_t           rsp_q, rsp_d;
   logic                unused_add_bits;

   // No grants while stalled or held in reset, so memory and pointer stay untouched.
   assign arb_en = !stall_i && !rst_i;

   tcdm_rr_arbiter #(.N(MP)) u_arb (
      .req_i   (tcdm.req),
      .ptr_i   (ptr_q),
      .en_i    (arb_en),
      .gnt_o   (gnt),
      .idx_o   (gnt_idx),
      .valid_o (gnt_valid)
   );

   assign tcdm.gnt = gnt;

   assign add_sel   = tcdm.add[gnt_idx];
   assign be_sel    = tcdm.be[gnt_idx];
   assign wdata_sel = tcdm.data[gnt_idx];
   assign wen_sel   = tcdm.wen[gnt_idx];
   assign widx      = add_sel[AW+1:2];
   assign wr_en     = gnt_valid && !wen_sel;

   // Byte offset and bits above the bank size alias onto the same word.
   assign unused_add_bits = ^{add_sel[TCDM_AW-1:AW+2], add_sel[1:0]};

   for (genvar i = 0; i < TCDM_BEW; i++) begin : g_lane
      logic [7:0] lane_q [DEPTH];

      always_ff @(posedge clk_i) begin
         if (wr_en && be_sel[i]) begin
            lane_q[widx] <= wdata_sel[8*i +: 8];
         end
      end

      assign rd_word[8*i +: 8] = lane_q[widx];
   end

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_valid) begin
         ptr_d = (gnt_idx == IW'(MP-1)) ? '0 : gnt_idx + IW'(1);
      end
   end

   always_comb begin
      rsp_d       = '0;
      rsp_d.valid = gnt_valid;
      rsp_d.port  = TCDM_PW'(gnt_idx);
      if (gnt_valid && wen_sel) begin
         rsp_d.data = rd_word;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= '0;
         rsp_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         rsp_q <= rsp_d;
      end
   end

   // Steer the registered response to its port; every other port sees zero.
   always_comb begin
      tcdm.r_valid = '0;
      tcdm.r_data  = '0;
      for (int unsigned p = 0; p < MP; p++) begin
         if (rsp_q.valid && rsp_q.port == TCDM_PW'(p)) begin
            tcdm.r_valid[p] = 1'b1;
            tcdm.r_data[p]  = rsp_q.data;
         end
      end
   end

   assign busy_o = rsp_q.valid;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Directed self-checking bench for tcdm_bank_responder.
module tb_tcdm_bank_responder;
   import tcdm_responder_package::*;

   localparam int unsigned MP    = 4;
   localparam int unsigned DEPTH = 1024;

   logic clk_i;
   logic rst_i;
   logic stall_i;
   logic busy_o;

   int n_chk;
   int n_pass;

   tcdm_bank_responder_if #(.MP(MP)) bus ();

   tcdm_bank_responder #(.MP(MP), .DEPTH(DEPTH)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .stall_i (stall_i),
      .tcdm    (bus.slave),
      .busy_o  (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic drv(input int p, input logic wen, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] d);
      bus.req[p]  = 1'b1;
      bus.wen[p]  = wen;
      bus.add[p]  = a;
      bus.be[p]   = be;
      bus.data[p] = d;
   endtask

   task automatic clr();
      bus.req = '0;
   endtask

   task automatic to_neg();
      @(negedge clk_i);
   endtask

   task automatic to_next();
      @(posedge clk_i);
      #1;
   endtask

   task automatic all_noop_writes();
      for (int p = 0; p < MP; p++) drv(p, 1'b0, 32'h40, 4'h0, 32'hFFFF_FFFF);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      clr();
      to_next();
      to_next();
      rst_i = 1'b0;
   endtask

   logic [3:0] exp_stall_gnt [12];
   int         cnt [MP];
   logic [3:0] prev;

   initial begin
      n_chk   = 0;
      n_pass  = 0;
      rst_i   = 1'b1;
      stall_i = 1'b0;
      bus.req = '0; bus.wen = '0; bus.add = '0; bus.be = '0; bus.data = '0;
      exp_stall_gnt = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h4, 4'h8};

      // Reset state: requests present but no grant, no response
      all_noop_writes();
      to_neg();
      chk("rst_gnt", 64'(bus.gnt), 64'h0);
      chk("rst_rvalid", 64'(bus.r_valid), 64'h0);
      chk("rst_rdata0", 64'(bus.r_data[0]), 64'h0);
      chk("rst_busy", 64'(busy_o), 64'h0);
      to_next();
      clr();
      rst_i = 1'b0;

      // Single write then read on port 0
      drv(0, 1'b0, 32'h40, 4'hF, 32'hDEAD_BEEF);
      to_neg();
      chk("wr_gnt", 64'(bus.gnt), 64'h1);
      to_next();
      clr();
      drv(0, 1'b1, 32'h40, 4'h0, 32'h0);
      to_neg();
      chk("rd_gnt", 64'(bus.gnt), 64'h1);
      chk("wr_rvalid", 64'(bus.r_valid), 64'h1);
      chk("wr_rdata", 64'(bus.r_data[0]), 64'h0);
      chk("wr_busy", 64'(busy_o), 64'h1);
      to_next();
      clr();
      to_neg();
      chk("rd_rvalid", 64'(bus.r_valid), 64'h1);
      chk("rd_rdata", 64'(bus.r_data[0]), 64'hDEAD_BEEF);
      chk("rd_other_zero", 64'(bus.r_data[1]), 64'h0);
      to_next();
      to_neg();
      chk("idle_rvalid", 64'(bus.r_valid), 64'h0);
      chk("idle_busy", 64'(busy_o), 64'h0);
      to_next();

      // Byte enables on port 2
      drv(2, 1'b0, 32'h100, 4'hF, 32'h1122_3344);
      to_next();
      clr();
      drv(2, 1'b0, 32'h100, 4'b0101, 32'hAABB_CCDD);
      to_next();
      clr();
      drv(2, 1'b1, 32'h100, 4'h0, 32'h0);
      to_next();
      clr();
      to_neg();
      chk("be_rvalid", 64'(bus.r_valid), 64'h4);
      chk("be_rdata", 64'(bus.r_data[2]), 64'h11BB_33DD);
      to_next();

      // Round robin from reset with be=0 no-op writes on all ports
      do_reset();
      for (int p = 0; p < MP; p++) cnt[p] = 0;
      prev = 4'h0;
      all_noop_writes();
      for (int c = 0; c < 100; c++) begin
         to_neg();
         chk($sformatf("rr_gnt%0d", c), 64'(bus.gnt), 64'(4'h1 << (c % 4)));
         chk($sformatf("rr_rv%0d", c), 64'(bus.r_valid), 64'(prev));
         for (int p = 0; p < MP; p++) if (bus.gnt[p]) cnt[p]++;
         prev = bus.gnt;
         to_next();
      end
      clr();
      for (int p = 0; p < MP; p++) chk($sformatf("rr_cnt%0d", p), 64'(cnt[p]), 64'd25);
      to_next();
      drv(1, 1'b1, 32'h40, 4'h0, 32'h0);
      to_next();
      clr();
      to_neg();
      chk("noop_keeps_data", 64'(bus.r_data[1]), 64'hDEAD_BEEF);
      to_next();

      // Stall in cycles 5..8 with all ports requesting
      do_reset();
      all_noop_writes();
      prev = 4'h0;
      for (int c = 0; c < 12; c++) begin
         stall_i = (c >= 5 && c <= 8);
         to_neg();
         chk($sformatf("st_gnt%0d", c), 64'(bus.gnt), 64'(exp_stall_gnt[c]));
         chk($sformatf("st_rv%0d", c), 64'(bus.r_valid), 64'(prev));
         prev = exp_stall_gnt[c];
         to_next();
      end
      stall_i = 1'b0;
      clr();
      to_next();

      // Aliasing plus read-after-write in consecutive cycles
      drv(1, 1'b0, 32'h0, 4'hF, 32'h5);
      to_next();
      clr();
      drv(3, 1'b1, 32'h1000, 4'h0, 32'h0);
      to_neg();
      chk("alias_gnt", 64'(bus.gnt), 64'h8);
      to_next();
      clr();
      to_neg();
      chk("alias_rdata", 64'(bus.r_data[3]), 64'h5);
      to_next();

      // Reset mid-flight drops the pending response, keeps memory
      drv(0, 1'b0, 32'h200, 4'hF, 32'hCAFE_F00D);
      to_next();
      clr();
      drv(2, 1'b1, 32'h200, 4'h0, 32'h0);
      to_neg();
      chk("mid_gnt", 64'(bus.gnt), 64'h4);
      rst_i = 1'b1;
      #1;
      chk("mid_gnt_rst", 64'(bus.gnt), 64'h0);
      chk("mid_rvalid", 64'(bus.r_valid), 64'h0);
      to_next();
      chk("mid_rvalid2", 64'(bus.r_valid), 64'h0);
      chk("mid_busy", 64'(busy_o), 64'h0);
      clr();
      rst_i = 1'b0;
      all_noop_writes();
      to_neg();
      chk("mid_ptr0", 64'(bus.gnt), 64'h1);
      to_next();
      clr();
      drv(3, 1'b1, 32'h200, 4'h0, 32'h0);
      to_next();
      clr();
      to_neg();
      chk("mid_keep_rv", 64'(bus.r_valid), 64'h8);
      chk("mid_keep_data", 64'(bus.r_data[3]), 64'hCAFE_F00D);
      to_next();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
